ctrl_mem_load: RTL and testbench

- Upstream control stage for the convolution pipeline.
- Accepts X and F samples from two AXI-stream-style slave interfaces and generates write enables and addresses for the X and F memories.
- Asserts conv_start once both memories are full, and holds it until the output controller returns conv_done.
- Then re-opens the input interfaces for the next vector.

---
 rtl/ctrl_mem_load.sv | 168 ++++++++++++++++
 tb/tb_ctrl_mem_load.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_mem_load.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_mem_load
// Purpose  : Upstream control stage of the convolution pipeline. Accepts X
//            samples and F coefficients on two valid/ready slave channels,
//            produces write strobes and addresses for the X and F memories,
//            raises conv_start once both memories are full, and holds it
//            until conv_done returns. The inputs then re-open for the next
//            vector.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-low reset
//            s_valid_x  / s_ready_x  - X sample handshake
//            s_valid_f  / s_ready_f  - F coefficient handshake
//            conv_done  - one-cycle pulse, all convolution outputs consumed
//            x_wr_en, x_wr_addr      - X memory write strobe / address
//            f_wr_en, f_wr_addr      - F memory write strobe / address
//            conv_start - both memories full, convolution may run
// Options  : F_KEEP_EN - when defined, the filter is loaded once after reset
//            and kept across rounds; only X is reloaded after conv_done.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_mem_load #(
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_SIZE       = 8,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid_x,
    output logic                        s_ready_x,
    input  logic                        s_valid_f,
    output logic                        s_ready_f,
    input  logic                        conv_done,
    output logic                        x_wr_en,
    output logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr,
    output logic                        f_wr_en,
    output logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr,
    output logic                        conv_start
);

    localparam logic [X_MEM_ADDR_WIDTH-1:0] c_x_last = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] c_f_last = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] c_x_one  = X_MEM_ADDR_WIDTH'(1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] c_f_one  = F_MEM_ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t                      state_q,      state_d;
    logic                        s_ready_x_q,  s_ready_x_d;
    logic                        s_ready_f_q,  s_ready_f_d;
    logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr_q,  x_wr_addr_d;
    logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr_q,  f_wr_addr_d;
    logic                        x_full_q,     x_full_d;
    logic                        f_full_q,     f_full_d;
    logic                        conv_start_q, conv_start_d;

    logic                        x_acc;
    logic                        f_acc;

    // Strobes are combinational so the write lands at the current address
    // in the same cycle as the handshake.
    assign x_acc = s_valid_x & s_ready_x_q;
    assign f_acc = s_valid_f & s_ready_f_q;

    always_comb begin
        state_d      = state_q;
        s_ready_x_d  = s_ready_x_q;
        s_ready_f_d  = s_ready_f_q;
        x_wr_addr_d  = x_wr_addr_q;
        f_wr_addr_d  = f_wr_addr_q;
        x_full_d     = x_full_q;
        f_full_d     = f_full_q;
        conv_start_d = conv_start_q;

        case (state_q)
            ST_LOAD: begin
                if (x_acc) begin
                    if (x_wr_addr_q == c_x_last) begin
                        x_wr_addr_d = '0;
                        x_full_d    = 1'b1;
                    end else begin
                        x_wr_addr_d = x_wr_addr_q + c_x_one;
                    end
                end
                if (f_acc) begin
                    if (f_wr_addr_q == c_f_last) begin
                        f_wr_addr_d = '0;
                        f_full_d    = 1'b1;
                    end else begin
                        f_wr_addr_d = f_wr_addr_q + c_f_one;
                    end
                end
                // Ready drops on the same edge that accepts the last beat,
                // so a write beyond the last address can never happen.
                s_ready_x_d = ~x_full_d;
                s_ready_f_d = ~f_full_d;

                // Uses the registered full flags: conv_start rises one cycle
                // after the edge that completes the later memory.
                if (x_full_q && f_full_q) begin
                    conv_start_d = 1'b1;
                    s_ready_x_d  = 1'b0;
                    s_ready_f_d  = 1'b0;
                    state_d      = ST_CONV;
                end
            end

            ST_CONV: begin
                s_ready_x_d  = 1'b0;
                s_ready_f_d  = 1'b0;
                conv_start_d = 1'b1;
                if (conv_done) begin
                    conv_start_d = 1'b0;
                    x_full_d     = 1'b0;
`ifdef F_KEEP_EN
                    // Filter stays resident until the next reset.
                    f_full_d     = f_full_q;
`else
                    f_full_d     = 1'b0;
`endif
                    s_ready_x_d  = 1'b1;
                    s_ready_f_d  = ~f_full_d;
                    state_d      = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_LOAD;
            s_ready_x_q  <= 1'b0;
            s_ready_f_q  <= 1'b0;
            x_wr_addr_q  <= '0;
            f_wr_addr_q  <= '0;
            x_full_q     <= 1'b0;
            f_full_q     <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_x_q  <= s_ready_x_d;
            s_ready_f_q  <= s_ready_f_d;
            x_wr_addr_q  <= x_wr_addr_d;
            f_wr_addr_q  <= f_wr_addr_d;
            x_full_q     <= x_full_d;
            f_full_q     <= f_full_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign s_ready_x  = s_ready_x_q;
    assign s_ready_f  = s_ready_f_q;
    assign x_wr_en    = x_acc;
    assign f_wr_en    = f_acc;
    assign x_wr_addr  = x_wr_addr_q;
    assign f_wr_addr  = f_wr_addr_q;
    assign conv_start = conv_start_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_mem_load.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_mem_load
// Purpose  : Directed self-checking bench for ctrl_mem_load (default sizes
//            X=8, F=4). Expected values are hand-derived per step. Build with
//            F_KEEP_EN defined to check the filter-retaining variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_mem_load;

`ifdef F_KEEP_EN
    localparam bit c_keep = 1'b1;
`else
    localparam bit c_keep = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid_x;
    logic       s_ready_x;
    logic       s_valid_f;
    logic       s_ready_f;
    logic       conv_done;
    logic       x_wr_en;
    logic [2:0] x_wr_addr;
    logic       f_wr_en;
    logic [1:0] f_wr_addr;
    logic       conv_start;

    int n_vec = 0;
    int n_err = 0;

    ctrl_mem_load #(
        .F_MEM_SIZE      (4),
        .X_MEM_SIZE      (8),
        .X_MEM_ADDR_WIDTH(3),
        .F_MEM_ADDR_WIDTH(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .s_valid_f (s_valid_f),
        .s_ready_f (s_ready_f),
        .conv_done (conv_done),
        .x_wr_en   (x_wr_en),
        .x_wr_addr (x_wr_addr),
        .f_wr_en   (f_wr_en),
        .f_wr_addr (f_wr_addr),
        .conv_start(conv_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after reset release with both valids already high.
    task automatic full_load();
        chk("pre_ready_x_wr_en", {31'd0, x_wr_en}, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("fl_ready_x", {31'd0, s_ready_x}, 32'd1);
            chk("fl_x_addr", {29'd0, x_wr_addr}, i);
            chk("fl_x_wr_en", {31'd0, x_wr_en}, 32'd1);
            if (i < 4) begin
                chk("fl_f_addr", {30'd0, f_wr_addr}, i);
                chk("fl_f_wr_en", {31'd0, f_wr_en}, 32'd1);
            end else begin
                chk("fl_f_wr_en_full", {31'd0, f_wr_en}, 32'd0);
                chk("fl_ready_f_full", {31'd0, s_ready_f}, 32'd0);
            end
            chk("fl_conv_start_lo", {31'd0, conv_start}, 32'd0);
            tick();
        end
        chk("fl_ready_x_drop", {31'd0, s_ready_x}, 32'd0);
        chk("fl_x_wr_en_full", {31'd0, x_wr_en}, 32'd0);
        chk("fl_x_addr_wrap", {29'd0, x_wr_addr}, 32'd0);
        chk("fl_f_addr_wrap", {30'd0, f_wr_addr}, 32'd0);
        chk("fl_conv_start_wait", {31'd0, conv_start}, 32'd0);
        tick();
        chk("fl_conv_start", {31'd0, conv_start}, 32'd1);
    endtask

    task automatic done_pulse();
        conv_done = 1'b1;
        #1;
        chk("dp_conv_start_before", {31'd0, conv_start}, 32'd1);
        tick();
        conv_done = 1'b0;
        chk("dp_conv_start_after", {31'd0, conv_start}, 32'd0);
        chk("dp_ready_x", {31'd0, s_ready_x}, 32'd1);
        chk("dp_ready_f", {31'd0, s_ready_f}, c_keep ? 32'd0 : 32'd1);
        chk("dp_x_addr", {29'd0, x_wr_addr}, 32'd0);
        chk("dp_f_addr", {30'd0, f_wr_addr}, 32'd0);
    endtask

    initial begin
        int exp_x;
        reset     = 1'b0;
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        conv_done = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready_x", {31'd0, s_ready_x}, 32'd0);
        chk("rst_ready_f", {31'd0, s_ready_f}, 32'd0);
        chk("rst_x_addr", {29'd0, x_wr_addr}, 32'd0);
        chk("rst_f_addr", {30'd0, f_wr_addr}, 32'd0);
        chk("rst_conv_start", {31'd0, conv_start}, 32'd0);

        // Round 1: continuous valids from reset release
        s_valid_x = 1'b1;
        s_valid_f = 1'b1;
        reset     = 1'b1;
        #1;
        full_load();

        // CONV hold: valids high, no writes, conv_start held
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("hold_x_wr_en", {31'd0, x_wr_en}, 32'd0);
            chk("hold_f_wr_en", {31'd0, f_wr_en}, 32'd0);
            chk("hold_conv_start", {31'd0, conv_start}, 32'd1);
        end
        done_pulse();

        // Round 2: X toggling, F idle, stray conv_done in LOAD ignored
        s_valid_f = 1'b0;
        exp_x = 0;
        for (int c = 0; c < 16; c++) begin
            s_valid_x = (c % 2 == 0);
            conv_done = (c == 3);
            #1;
            chk("tog_x_wr_en", {31'd0, x_wr_en}, {31'd0, s_valid_x});
            chk("tog_x_addr", {29'd0, x_wr_addr}, exp_x);
            chk("tog_f_wr_en", {31'd0, f_wr_en}, 32'd0);
            chk("tog_conv_start", {31'd0, conv_start}, 32'd0);
            tick();
            if (c % 2 == 0) exp_x = (exp_x + 1) % 8;
        end
        conv_done = 1'b0;
        s_valid_x = 1'b0;
        chk("tog_ready_x_drop", {31'd0, s_ready_x}, 32'd0);
        chk("tog_x_addr_wrap", {29'd0, x_wr_addr}, 32'd0);
`ifdef F_KEEP_EN
        tick();
        chk("keep_conv_start_x_only", {31'd0, conv_start}, 32'd1);
`else
        tick();
        tick();
        chk("tog_no_f_no_start", {31'd0, conv_start}, 32'd0);
        s_valid_f = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("r2_f_addr", {30'd0, f_wr_addr}, i);
            chk("r2_f_wr_en", {31'd0, f_wr_en}, 32'd1);
            tick();
        end
        s_valid_f = 1'b0;
        chk("r2_conv_start_wait", {31'd0, conv_start}, 32'd0);
        tick();
        chk("r2_conv_start", {31'd0, conv_start}, 32'd1);
`endif
        done_pulse();

        // Round 3: last X and last F beats on the same edge
        for (int c = 0; c < 8; c++) begin
            s_valid_x = 1'b1;
            s_valid_f = (c >= 4);
            #1;
            chk("sim_x_addr", {29'd0, x_wr_addr}, c);
            chk("sim_x_wr_en", {31'd0, x_wr_en}, 32'd1);
            chk("sim_f_wr_en", {31'd0, f_wr_en}, (!c_keep && c >= 4) ? 32'd1 : 32'd0);
            chk("sim_f_addr", {30'd0, f_wr_addr}, (!c_keep && c >= 4) ? c - 4 : 0);
            tick();
        end
        chk("sim_conv_start_wait", {31'd0, conv_start}, 32'd0);
        chk("sim_no_x_extra", {31'd0, x_wr_en}, 32'd0);
        chk("sim_no_f_extra", {31'd0, f_wr_en}, 32'd0);
        tick();
        chk("sim_conv_start", {31'd0, conv_start}, 32'd1);
        chk("sim_no_x_extra2", {31'd0, x_wr_en}, 32'd0);
        done_pulse();

        // Mid-load reset after 5 X beats (and 2 F beats where F is open)
        for (int c = 0; c < 5; c++) begin
            s_valid_x = 1'b1;
            s_valid_f = (c < 2);
            tick();
        end
        s_valid_f = 1'b0;
        chk("mid_x_addr", {29'd0, x_wr_addr}, 32'd5);
        chk("mid_f_addr", {30'd0, f_wr_addr}, c_keep ? 32'd0 : 32'd2);
        reset = 1'b0;
        #1;
        chk("arst_ready_x", {31'd0, s_ready_x}, 32'd0);
        chk("arst_ready_f", {31'd0, s_ready_f}, 32'd0);
        chk("arst_x_addr", {29'd0, x_wr_addr}, 32'd0);
        chk("arst_f_addr", {30'd0, f_wr_addr}, 32'd0);
        chk("arst_x_wr_en", {31'd0, x_wr_en}, 32'd0);
        chk("arst_conv_start", {31'd0, conv_start}, 32'd0);
        tick();
        s_valid_x = 1'b1;
        s_valid_f = 1'b1;
        reset     = 1'b1;
        #1;
        full_load();
        done_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
